multi_edge_detect: RTL and testbench

Parametrised multi-channel input conditioner: synchronises `WIDTH` asynchronous inputs through a configurable flop chain, optionally debounces each channel, and produces per-channel rising/falling edge pulses plus sticky, software-clearable event flags. It sits between raw board-level inputs (buttons, external strobes) and the synchronous control logic. It is the generalised successor of the single-channel rising-edge synchroniser.

---
 rtl/edge_pkg.sv | 30 +++
 rtl/sync_debounce_channel.sv | 62 ++++++
 rtl/multi_edge_detect.sv | 77 +++++++
 tb/tb_multi_edge_detect.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Provides the event-mode encoding, mode decode helpers and a
// parameter-legality function used for elaboration-time checks.
package edge_pkg;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_OFF  = 2'b11
   } edge_mode_t;

   // Mode selects rising edges as events
   function automatic logic rise_selected(edge_mode_t m);
      return (m == EDGE_RISE) || (m == EDGE_BOTH);
   endfunction

   // Mode selects falling edges as events
   function automatic logic fall_selected(edge_mode_t m);
      return (m == EDGE_FALL) || (m == EDGE_BOTH);
   endfunction

   // Legal parameter combination for the detector
   function automatic bit params_legal(int unsigned width,
                                       int unsigned sync_stages,
                                       int unsigned debounce_cycles);
      return (width >= 1) && (sync_stages >= 2) && (debounce_cycles >= 1);
   endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One input channel: synchroniser chain, debounce filter, registered
// edge pulses.
// Ports:
//   clk, nrst            clock, async active-low reset
//   din                  raw asynchronous input
//   level                debounced stable level (registered)
//   pos_edge, neg_edge   one-cycle pulses when level changes (registered)
//   pos_nxt_c, neg_nxt_c combinational next values of the pulses
module sync_debounce_channel #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic nrst,
   input  logic din,
   output logic level,
   output logic pos_edge,
   output logic neg_edge,
   output logic pos_nxt_c,
   output logic neg_nxt_c
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   s;
   logic                   accept_c;

   assign s = sync_q[SYNC_STAGES-1];

   // Accept once the synced value has differed from level long enough
   assign accept_c  = (s != level) && (cnt_q == CNT_LAST);
   assign pos_nxt_c = accept_c & s;
   assign neg_nxt_c = accept_c & ~s;

   // Synchroniser, debounce counter, accepted level and pulses
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         level    <= 1'b0;
         pos_edge <= 1'b0;
         neg_edge <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         if (s == level) begin
            // Agreement restarts the count, rejecting short glitches
            cnt_q <= '0;
         end else if (accept_c) begin
            level <= s;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         pos_edge <= pos_nxt_c;
         neg_edge <= neg_nxt_c;
      end
   end

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel input conditioner: per-channel synchronise + debounce,
// edge pulses, mode-selected sticky event flags with per-channel clear.
// Ports:
//   clk, nrst            clock, async active-low reset
//   async_in[WIDTH]      raw asynchronous inputs
//   mode[2]              event select: 00 rise, 01 fall, 10 both, 11 off
//   clr[WIDTH]           sticky-flag clear pulses
//   level[WIDTH]         debounced levels
//   pos_edge, neg_edge   one-cycle edge pulses per channel
//   event_flag[WIDTH]    sticky event flags
//   any_event            OR of event_flag (combinational)
module multi_edge_detect
   import edge_pkg::*;
#(
   parameter  int unsigned WIDTH           = 4,
   parameter  int unsigned SYNC_STAGES     = 2,
   parameter  int unsigned DEBOUNCE_CYCLES = 1,
   localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [WIDTH-1:0] async_in,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] clr,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] pos_edge,
   output logic [WIDTH-1:0] neg_edge,
   output logic [WIDTH-1:0] event_flag,
   output logic             any_event
);

   if (!params_legal(WIDTH, SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_param_check
      $error("multi_edge_detect: illegal WIDTH=%0d SYNC_STAGES=%0d DEBOUNCE_CYCLES=%0d",
             WIDTH, SYNC_STAGES, DEBOUNCE_CYCLES);
   end

   logic [WIDTH-1:0] pos_nxt_c;
   logic [WIDTH-1:0] neg_nxt_c;
   logic [WIDTH-1:0] ev_c;
   edge_mode_t       mode_c;

   // Independent conditioning per channel
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      sync_debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk       (clk),
         .nrst      (nrst),
         .din       (async_in[i]),
         .level     (level[i]),
         .pos_edge  (pos_edge[i]),
         .neg_edge  (neg_edge[i]),
         .pos_nxt_c (pos_nxt_c[i]),
         .neg_nxt_c (neg_nxt_c[i])
      );
   end

   assign mode_c = edge_mode_t'(mode);

   // Events use next-cycle pulses so flags rise together with the pulse
   assign ev_c = (pos_nxt_c & {WIDTH{rise_selected(mode_c)}})
               | (neg_nxt_c & {WIDTH{fall_selected(mode_c)}});

   // Sticky flags; a new event wins over a simultaneous clear
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         event_flag <= '0;
      end else begin
         event_flag <= ev_c | (event_flag & ~clr);
      end
   end

   assign any_event = |event_flag;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Scoreboard bench for multi_edge_detect: two instances (default and
// slow/filtered parameters) share stimulus; a window-based reference
// model predicts outputs per clock, a monitor compares after each edge.
module tb_multi_edge_detect;

   localparam int unsigned F_SYNC = 2;
   localparam int unsigned F_DEB  = 1;
   localparam int unsigned S_SYNC = 3;
   localparam int unsigned S_DEB  = 4;

   typedef struct packed {
      logic [3:0] level;
      logic [3:0] pos;
      logic [3:0] neg;
      logic [3:0] flag;
      logic       any;
   } obs_t;

   logic       clk = 1'b0;
   logic       nrst;
   logic [3:0] async_in;
   logic [1:0] mode;
   logic [3:0] clr;

   logic [3:0] level_f, pos_f, neg_f, flag_f;
   logic       any_f;
   logic [3:0] level_s, pos_s, neg_s, flag_s;
   logic       any_s;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   multi_edge_detect #(.WIDTH(4), .SYNC_STAGES(F_SYNC), .DEBOUNCE_CYCLES(F_DEB)) u_fast (
      .clk(clk), .nrst(nrst), .async_in(async_in), .mode(mode), .clr(clr),
      .level(level_f), .pos_edge(pos_f), .neg_edge(neg_f),
      .event_flag(flag_f), .any_event(any_f)
   );

   multi_edge_detect #(.WIDTH(4), .SYNC_STAGES(S_SYNC), .DEBOUNCE_CYCLES(S_DEB)) u_slow (
      .clk(clk), .nrst(nrst), .async_in(async_in), .mode(mode), .clr(clr),
      .level(level_s), .pos_edge(pos_s), .neg_edge(neg_s),
      .event_flag(flag_s), .any_event(any_s)
   );

   // ---------------- reference model ----------------
   // hist[k] is async_in as sampled at the k-th clock since reset release.
   // At edge k the debouncer sees the value sampled SYNC edges earlier;
   // a level change is accepted when the last DEB seen values all differ.
   logic [3:0] hist[$];
   logic [3:0] m_lvl  [2];
   logic [3:0] m_flag [2];
   obs_t       exp_f[$];
   obs_t       exp_s[$];

   task automatic model_edge(input int inst, output obs_t o);
      int         s_n, d_n, idx;
      logic [3:0] h, ev;
      logic       acc;
      s_n = (inst == 0) ? int'(F_SYNC) : int'(S_SYNC);
      d_n = (inst == 0) ? int'(F_DEB)  : int'(S_DEB);
      o = '0;
      for (int ch = 0; ch < 4; ch++) begin
         acc = 1'b1;
         for (int j = 0; j < d_n; j++) begin
            idx = hist.size() - 1 - s_n - j;
            h   = (idx >= 0) ? hist[idx] : 4'h0;
            if (h[ch] == m_lvl[inst][ch]) acc = 1'b0;
         end
         if (acc) begin
            if (m_lvl[inst][ch]) o.neg[ch] = 1'b1;
            else                 o.pos[ch] = 1'b1;
            m_lvl[inst][ch] = ~m_lvl[inst][ch];
         end
      end
      case (mode)
         2'b00:   ev = o.pos;
         2'b01:   ev = o.neg;
         2'b10:   ev = o.pos | o.neg;
         default: ev = 4'h0;
      endcase
      m_flag[inst] = ev | (m_flag[inst] & ~clr);
      o.level = m_lvl[inst];
      o.flag  = m_flag[inst];
      o.any   = (m_flag[inst] != 4'h0);
   endtask

   // Predict outputs for each clock edge and queue them
   always @(posedge clk) begin
      obs_t of, os;
      if (!nrst) begin
         hist.delete();
         for (int i = 0; i < 2; i++) begin
            m_lvl[i]  = 4'h0;
            m_flag[i] = 4'h0;
         end
         of = '0;
         os = '0;
      end else begin
         hist.push_back(async_in);
         model_edge(0, of);
         model_edge(1, os);
      end
      exp_f.push_back(of);
      exp_s.push_back(os);
   end

   // ---------------- monitor ----------------
   task automatic compare(input string name, input obs_t exp, input obs_t act);
      n_checks++;
      if (exp === act) begin
         n_pass++;
      end else begin
         $display("FAIL %s cyc=%0d: got lvl=%h pos=%h neg=%h flag=%h any=%b, want lvl=%h pos=%h neg=%h flag=%h any=%b",
                  name, cyc, act.level, act.pos, act.neg, act.flag, act.any,
                  exp.level, exp.pos, exp.neg, exp.flag, exp.any);
      end
   endtask

   always @(posedge clk) begin
      #2;
      cyc++;
      if (exp_f.size() == 0 || exp_s.size() == 0) begin
         n_checks++;
         $display("FAIL scoreboard_empty cyc=%0d: got queue sizes %0d/%0d, want >0",
                  cyc, exp_f.size(), exp_s.size());
      end else begin
         compare("fast", exp_f.pop_front(), {level_f, pos_f, neg_f, flag_f, any_f});
         compare("slow", exp_s.pop_front(), {level_s, pos_s, neg_s, flag_s, any_s});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      async_in = 4'hF;
      mode     = 2'b00;
      clr      = 4'h0;
      nrst     = 1'b1;
      #1 nrst  = 1'b0;

      // Inputs held high through reset release
      cycles(3);
      nrst = 1'b1;
      cycles(10);
      async_in = 4'h0;
      cycles(12);
      clr = 4'hF;
      cycles(1);
      clr = 4'h0;

      // Short high on ch1 (rejected by the filtered instance), then a long one
      async_in[1] = 1'b1;
      cycles(3);
      async_in[1] = 1'b0;
      cycles(12);
      async_in[1] = 1'b1;
      cycles(4);
      async_in[1] = 1'b0;
      cycles(12);

      // Fall-only, both, disabled modes on ch2
      for (int m = 1; m < 4; m++) begin
         clr = 4'hF;
         cycles(1);
         clr  = 4'h0;
         mode = 2'(m);
         async_in[2] = 1'b1;
         cycles(10);
         async_in[2] = 1'b0;
         cycles(10);
      end

      // Clear coinciding with a selected rising edge on ch3, then a lone clear
      clr  = 4'hF;
      mode = 2'b00;
      cycles(1);
      clr = 4'h0;
      async_in[3] = 1'b1;
      cycles(2);
      clr[3] = 1'b1;
      cycles(1);
      clr = 4'h0;
      cycles(6);
      clr[3] = 1'b1;
      cycles(1);
      clr = 4'h0;
      cycles(3);

      // Reset during an active debounce count
      async_in = 4'h0;
      cycles(12);
      async_in[0] = 1'b1;
      cycles(5);
      nrst = 1'b0;
      #1;
      n_checks++;
      if ({level_f, pos_f, neg_f, flag_f, any_f, level_s, pos_s, neg_s, flag_s, any_s} == '0)
         n_pass++;
      else
         $display("FAIL async_reset: got fast=%h slow=%h, want 0",
                  {level_f, pos_f, neg_f, flag_f, any_f}, {level_s, pos_s, neg_s, flag_s, any_s});
      @(negedge clk);
      nrst = 1'b1;
      cycles(12);

      // Toggle every cycle
      async_in = 4'h0;
      cycles(12);
      for (int i = 0; i < 12; i++) begin
         async_in = ~async_in;
         cycles(1);
      end
      async_in = 4'h0;
      cycles(12);

      // Randomised traffic
      for (int i = 0; i < 800; i++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(5) == 0) async_in[b] = ~async_in[b];
         if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
         clr  = ($urandom_range(11) == 0) ? 4'($urandom) : 4'h0;
         nrst = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
         cycles(1);
      end
      nrst = 1'b1;
      clr  = 4'h0;
      cycles(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
